flash_emu: RTL
==============

# flash_emu

Clocked, synthesizable emulator of a parallel NOR flash device with a JEDEC/Intel-style command set, parametrised in address width, data width and block size. It replaces the untimed flash model in scoreboard simulations and FPGA loopback builds, presenting the same active-low `NF_*` pin interface to the flash controller. It adds a command state machine, a status register, timed program/erase busy periods with `NF_STS`, and NOR program semantics (bits may only go 1 to 0).

## Interface
- `ADDR_W`, 8, address bits; depth is 2**ADDR_W words.
- `DATA_W`, 8, data word width; must be at least 8.
- `BLOCK_W`, 4, address bits per erase block; 2**BLOCK_W words per block; requires BLOCK_W < ADDR_W.
- `PROG_CYCLES`, 16, clk cycles a program operation stays busy; must be at least 1.
- `ERASE_CYCLES`, 64, clk cycles an erase stays busy; must be at least 2**BLOCK_W.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `NF_A`  in  ADDR_W  word address.
- `NF_D`  inout  DATA_W  data bus; driven only during reads.
- `NF_CE`  in  1  chip enable, active low.
- `NF_OE`  in  1  output enable, active low.
- `NF_WE`  in  1  write enable, active low.
- `NF_RP`  in  1  reset/power-down, active low.
- `NF_WP`  in  1  write protect, active low. Used only with `FLASH_EMU_WP_EN`.
- `NF_STS`  out  1  1 = ready, 0 = busy.

## Operation
- Modes: READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP, PROG_BUSY, ERASE_BUSY.
- Status register SR[7:0]; upper bits are zero when DATA_W > 8:
  - SR7: ready.
  - SR5: erase error.
  - SR4: program error.
  - SR1: protect error.
- Write cycle: recognised on the first clk edge where the registered `NF_WE` is high, the previous registered `NF_WE` was low, and the registered `NF_CE` is low. Address and data come from the registered `NF_A`/`NF_D` of the last cycle with `NF_WE` low.
- Commands (low 8 bits of data) from READ_ARRAY, READ_STATUS or SETUP:
  - 0xFF: go to READ_ARRAY.
  - 0x70: go to READ_STATUS.
  - 0x50: clear SR5, SR4, SR1.
  - 0x40: go to PROG_SETUP.
  - 0x20: go to ERASE_SETUP.
  - Any other code: ignored.
- PROG_SETUP, next write cycle: latch address and data, go to PROG_BUSY.
  - After PROG_CYCLES cycles: `mem[a] <= mem[a] & d`.
  - If `d` would set any 0 bit to 1, also set SR4.
  - Then go to READ_STATUS.
- ERASE_SETUP, next write cycle:
  - Data 0xD0: latch block `a[ADDR_W-1:BLOCK_W]`, go to ERASE_BUSY.
  - Other data: set SR5 and SR4, go to READ_STATUS, memory untouched.
- ERASE_BUSY: write all-ones to one block word per cycle, ascending from offset 0, for the first 2**BLOCK_W cycles. Stay busy until ERASE_CYCLES cycles total, then go to READ_STATUS.
- During PROG_BUSY/ERASE_BUSY:
  - All write cycles are ignored.
  - Reads return SR.
  - SR7 = 0 and `NF_STS` = 0.
- Read data:
  - READ_ARRAY: `mem[NF_A]`.
  - READ_STATUS, SETUP, BUSY: SR.
- Bus drive: `NF_D` is driven when `NF_CE`=0, `NF_OE`=0, `NF_WE`=1 and `NF_RP`=1; otherwise high-Z.
- `NF_RP`=0 (synchronous):
  - Aborts any operation and forces READ_ARRAY.
  - Clears SR to 0x80 and sets `NF_STS`=1.
  - Words already written by an aborted erase stay erased.
- Memory powers up all ones. `rst` and `NF_RP` never alter memory contents.

## Timing
- Reset values:
  - Mode READ_ARRAY, SR = 0x80, `NF_STS` = 1.
  - Output data register = 0; `NF_D` high-Z.
  - Busy counter = 0; input registers = idle (`NF_WE`/`NF_CE`/`NF_OE` high).
- Read latency: `NF_D` reflects `NF_A`/mode 1 clk after they are registered, i.e. 2 edges from pin change. Output enable follows the pins combinationally.
- Command effect: new mode is visible on reads 1 clk after the write-cycle detection edge.
- `NF_STS` falls on the same edge the BUSY mode is entered. It rises on the edge BUSY exits, exactly PROG_CYCLES or ERASE_CYCLES cycles later.
- Simultaneous `NF_RP`=0 and a write cycle: `NF_RP` wins and the command is discarded.
- Busy counter width is clog2(ERASE_CYCLES+1). Erase offset counter is BLOCK_W bits and does not wrap within an operation.

## Configuration
- `FLASH_EMU_WP_EN` defined: a program or erase confirm with `NF_WP`=0 does not enter BUSY. It sets SR1 plus SR4 (program) or SR5 (erase), goes to READ_STATUS, and leaves memory unchanged.
- `FLASH_EMU_WP_EN` undefined: `NF_WP` is ignored and SR1 is always 0.

## Structure
- Package `flash_emu_pkg`: command codes (0xFF, 0x70, 0x50, 0x40, 0x20, 0xD0), SR bit indices, mode enum.
- Sub-module `flash_emu_wr_detect`: registers the `NF_*` inputs and emits a one-cycle `wr_stb` with the captured address and data.
- Top level holds the FSM, SR, counters, memory array and tristate.

## Test plan
- Reset, then read `A`=0x10 -> 0xFF; `NF_STS`=1; read 0x70 command then read -> 0x80.
- Program 0x40 then 0xA5 at 0x10 -> `NF_STS` low for 16 cycles, SR=0x80, after 0xFF read 0x10 -> 0xA5.
- Program 0x5A over 0xA5 at 0x10 -> word 0x00, SR4 set (SR=0x90); 0x50 -> SR=0x80.
- Erase 0x20 then 0xD0 at 0x13 -> busy 64 cycles; 0x10–0x1F read 0xFF, 0x20 unchanged; 0x20 then 0x00 -> SR=0xB0, no busy.
- `NF_RP` pulsed low mid-erase at cycle 5 -> `NF_STS`=1 next edge, READ_ARRAY; block offsets 0–4 read 0xFF, other words unchanged.
- With `FLASH_EMU_WP_EN` and `NF_WP`=0: program at 0x30 -> SR=0x92, no busy, word unchanged.

Source files
------------

// File: rtl/flash_emu_pkg.sv
// Shared command codes, status-register bit positions and mode encoding for flash_emu.
package flash_emu_pkg;
  localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;
  localparam logic [7:0] CMD_CLEAR_SR    = 8'h50;
  localparam logic [7:0] CMD_PROG        = 8'h40;
  localparam logic [7:0] CMD_ERASE       = 8'h20;
  localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_PROT_ERR  = 1;

  typedef enum logic [2:0] {
    READ_ARRAY,
    READ_STATUS,
    PROG_SETUP,
    ERASE_SETUP,
    PROG_BUSY,
    ERASE_BUSY
  } mode_e;
endpackage

// File: rtl/flash_emu_wr_detect.sv
// Registers the flash pins and emits a one-cycle write strobe on the rising edge of
// the registered write enable, with address/data from the last cycle it was low.
module flash_emu_wr_detect #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] NF_A,
  input  logic [DATA_W-1:0] NF_D,
  input  logic              NF_CE,
  input  logic              NF_WE,
  output logic [ADDR_W-1:0] rd_a,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_a,
  output logic [DATA_W-1:0] wr_d
);
  logic [DATA_W-1:0] d_q;
  logic              ce_q, we_q, we_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a <= '0;
      d_q  <= '0;
      ce_q <= 1'b1;
      we_q <= 1'b1;
      we_p <= 1'b1;
      wr_a <= '0;
      wr_d <= '0;
    end else begin
      rd_a <= NF_A;
      d_q  <= NF_D;
      ce_q <= NF_CE;
      we_q <= NF_WE;
      we_p <= we_q;
      // hold the operands sampled while the registered write enable was still low
      if (!we_q) begin
        wr_a <= rd_a;
        wr_d <= d_q;
      end
    end
  end

  assign wr_stb = we_q & ~we_p & ~ce_q;
endmodule

// File: rtl/flash_emu.sv
// Clocked NOR flash emulator: command FSM, status register, timed program/erase.
// Optional write protect via FLASH_EMU_WP_EN.
module flash_emu
  import flash_emu_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int BLOCK_W      = 4,
  parameter int PROG_CYCLES  = 16,
  parameter int ERASE_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] NF_A,
  inout  wire  [DATA_W-1:0] NF_D,
  input  logic              NF_CE,
  input  logic              NF_OE,
  input  logic              NF_WE,
  input  logic              NF_RP,
  input  logic              NF_WP,
  output logic              NF_STS
);
  localparam int CW         = $clog2(ERASE_CYCLES + 1);
  localparam int ERASE_TAIL = ERASE_CYCLES - 2**BLOCK_W;

  mode_e                    mode, mode_nx;
  logic [CW-1:0]            cnt, cnt_nx;
  logic [BLOCK_W-1:0]       off, off_nx;
  logic [ADDR_W-BLOCK_W-1:0] blk, blk_nx;
  logic [ADDR_W-1:0]        lat_a, lat_a_nx;
  logic [DATA_W-1:0]        lat_d, lat_d_nx;
  logic                     sr5, sr4, sr1, sr5_nx, sr4_nx, sr1_nx;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_wa;
  logic [DATA_W-1:0]        mem_wd;
  logic [DATA_W-1:0]        rd_q;
  logic [7:0]               sr8;
  logic                     busy, wp_block;
  logic [ADDR_W-1:0]        rd_a, wr_a;
  logic [DATA_W-1:0]        wr_d;
  logic                     wr_stb;

  // stored inverted so a zero-initialised array reads as erased
  logic [DATA_W-1:0] mem_n [2**ADDR_W];

  flash_emu_wr_detect #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_detect (
    .clk(clk), .rst(rst), .NF_A(NF_A), .NF_D(NF_D), .NF_CE(NF_CE), .NF_WE(NF_WE),
    .rd_a(rd_a), .wr_stb(wr_stb), .wr_a(wr_a), .wr_d(wr_d)
  );

`ifdef FLASH_EMU_WP_EN
  assign wp_block = ~NF_WP;
`else
  logic wp_unused;
  assign wp_unused = NF_WP;
  assign wp_block  = 1'b0;
`endif

  assign busy   = (mode == PROG_BUSY) || (mode == ERASE_BUSY);
  assign NF_STS = ~busy;

  always_comb begin
    sr8               = '0;
    sr8[SR_READY]     = ~busy;
    sr8[SR_ERASE_ERR] = sr5;
    sr8[SR_PROG_ERR]  = sr4;
    sr8[SR_PROT_ERR]  = sr1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode  <= READ_ARRAY;
      cnt   <= '0;
      off   <= '0;
      blk   <= '0;
      lat_a <= '0;
      lat_d <= '0;
      sr5   <= 1'b0;
      sr4   <= 1'b0;
      sr1   <= 1'b0;
      rd_q  <= '0;
    end else begin
      mode  <= mode_nx;
      cnt   <= cnt_nx;
      off   <= off_nx;
      blk   <= blk_nx;
      lat_a <= lat_a_nx;
      lat_d <= lat_d_nx;
      sr5   <= sr5_nx;
      sr4   <= sr4_nx;
      sr1   <= sr1_nx;
      rd_q  <= (mode == READ_ARRAY) ? ~mem_n[rd_a] : DATA_W'(sr8);
    end
  end

  always_comb begin
    mode_nx  = mode;
    cnt_nx   = cnt;
    off_nx   = off;
    blk_nx   = blk;
    lat_a_nx = lat_a;
    lat_d_nx = lat_d;
    sr5_nx   = sr5;
    sr4_nx   = sr4;
    sr1_nx   = sr1;
    mem_we   = 1'b0;
    mem_wa   = lat_a;
    mem_wd   = mem_n[lat_a] | ~lat_d;
    if (!NF_RP) begin
      mode_nx = READ_ARRAY;
      cnt_nx  = '0;
      off_nx  = '0;
      sr5_nx  = 1'b0;
      sr4_nx  = 1'b0;
      sr1_nx  = 1'b0;
    end else begin
      case (mode)
        READ_ARRAY, READ_STATUS: begin
          if (wr_stb) begin
            case (wr_d[7:0])
              CMD_READ_ARRAY:  mode_nx = READ_ARRAY;
              CMD_READ_STATUS: mode_nx = READ_STATUS;
              CMD_CLEAR_SR: begin
                sr5_nx = 1'b0;
                sr4_nx = 1'b0;
                sr1_nx = 1'b0;
              end
              CMD_PROG:  mode_nx = PROG_SETUP;
              CMD_ERASE: mode_nx = ERASE_SETUP;
              default: ;
            endcase
          end
        end
        PROG_SETUP: begin
          if (wr_stb) begin
            if (wp_block) begin
              sr1_nx  = 1'b1;
              sr4_nx  = 1'b1;
              mode_nx = READ_STATUS;
            end else begin
              lat_a_nx = wr_a;
              lat_d_nx = wr_d;
              cnt_nx   = CW'(PROG_CYCLES);
              mode_nx  = PROG_BUSY;
            end
          end
        end
        ERASE_SETUP: begin
          if (wr_stb) begin
            if (wr_d[7:0] != CMD_CONFIRM) begin
              sr5_nx  = 1'b1;
              sr4_nx  = 1'b1;
              mode_nx = READ_STATUS;
            end else if (wp_block) begin
              sr1_nx  = 1'b1;
              sr5_nx  = 1'b1;
              mode_nx = READ_STATUS;
            end else begin
              blk_nx  = wr_a[ADDR_W-1:BLOCK_W];
              off_nx  = '0;
              cnt_nx  = CW'(ERASE_CYCLES);
              mode_nx = ERASE_BUSY;
            end
          end
        end
        PROG_BUSY: begin
          cnt_nx = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            mem_we = 1'b1;
            // a 1 in the data over a stored 0 cannot be programmed
            if (|(lat_d & mem_n[lat_a])) sr4_nx = 1'b1;
            mode_nx = READ_STATUS;
          end
        end
        ERASE_BUSY: begin
          cnt_nx = cnt - 1'b1;
          if (cnt > CW'(ERASE_TAIL)) begin
            mem_we = 1'b1;
            mem_wa = {blk, off};
            mem_wd = '0;
            if (off != '1) off_nx = off + 1'b1;
          end
          if (cnt == CW'(1)) mode_nx = READ_STATUS;
        end
        default: mode_nx = READ_ARRAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_n[mem_wa] <= mem_wd;
  end

  assign NF_D = (~NF_CE & ~NF_OE & NF_WE & NF_RP) ? rd_q : 'z;
endmodule
